// File: rtl/rolagem_pkg.sv
// rolagem_pkg: shared types and constants for the scrolling-window controller.
`default_nettype none

package rolagem_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    PUBLICA = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  localparam int LARGURA_JANELA = 4;
  localparam int LARGURA_CHAR   = 5;
  localparam logic [LARGURA_CHAR-1:0] CHAR_ESPACO = 5'h00;

endpackage

`default_nettype wire

// File: rtl/divisor_passo.sv
// divisor_passo: step counter 0..CICLOS_PASSO-1 with enable, synchronous clear
// and a terminal flag raised while the count sits at its last value.
`default_nettype none

module divisor_passo #(
  parameter int CICLOS_PASSO = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic habilita,
  input  logic limpa,
  output logic terminal
);

  localparam int LARGURA = (CICLOS_PASSO > 1) ? $clog2(CICLOS_PASSO) : 1;
  localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(CICLOS_PASSO - 1);

  logic [LARGURA-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= '0;
    end else if (limpa) begin
      contagem <= '0;
    end else if (habilita) begin
      contagem <= (contagem == ULTIMO) ? '0 : contagem + LARGURA'(1);
    end
  end

  assign terminal = (contagem == ULTIMO);

endmodule

`default_nettype wire

// File: rtl/rolagem_frase.sv
// rolagem_frase: reads a 4-character window from the phrase ROM into a shadow
// buffer and publishes it atomically, advancing one position per step.
`default_nettype none

module rolagem_frase
  import rolagem_pkg::*;
#(
  parameter int CICLOS_PASSO = 25_000_000,
  parameter int NUM_POSICOES = 21
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   habilita,
  input  logic                                   reinicia,
  output logic [4:0]                             endereco_rom,
  input  logic [LARGURA_CHAR-1:0]                dado_rom,
  output logic [LARGURA_JANELA*LARGURA_CHAR-1:0] janela,
  output logic [4:0]                             posicao,
  output logic                                   quadro_pronto
);

  localparam logic [4:0] ULTIMA_POSICAO = 5'(NUM_POSICOES - 1);
  localparam logic [1:0] ULTIMO_K       = 2'(LARGURA_JANELA - 1);

  estado_t                 estado;
  logic [1:0]              k;
  logic [LARGURA_CHAR-1:0] sombra [LARGURA_JANELA];
  logic [LARGURA_JANELA*LARGURA_CHAR-1:0] sombra_empacotada;

  logic passo_terminal;
  logic passo_habilita;
  logic passo_limpa;

  // The counter runs in every active state so the step period includes the
  // load and publish cycles; it restarts whenever a fresh run begins.
  assign passo_habilita = habilita && (estado != OCIOSO);
  assign passo_limpa    = reinicia || ((estado == OCIOSO) && habilita);

  divisor_passo #(
    .CICLOS_PASSO (CICLOS_PASSO)
  ) u_divisor_passo (
    .clock    (clock),
    .reset    (reset),
    .habilita (passo_habilita),
    .limpa    (passo_limpa),
    .terminal (passo_terminal)
  );

  always_comb begin
    endereco_rom = posicao;
    if (estado == CARREGA) begin
      endereco_rom = posicao + 5'(k);
    end
  end

  // Leftmost character (shadow[0]) lands in the most significant slot.
  always_comb begin
    sombra_empacotada = '0;
    for (int i = 0; i < LARGURA_JANELA; i++) begin
      sombra_empacotada[(LARGURA_JANELA-1-i)*LARGURA_CHAR +: LARGURA_CHAR] = sombra[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      posicao       <= '0;
      k             <= '0;
      janela        <= {LARGURA_JANELA{CHAR_ESPACO}};
      quadro_pronto <= 1'b0;
      for (int i = 0; i < LARGURA_JANELA; i++) begin
        sombra[i] <= CHAR_ESPACO;
      end
    end else begin
      quadro_pronto <= 1'b0;
      if (reinicia) begin
        posicao <= '0;
        k       <= '0;
        estado  <= habilita ? CARREGA : OCIOSO;
      end else begin
        case (estado)
          OCIOSO: begin
            if (habilita) begin
              k      <= '0;
              estado <= CARREGA;
            end
          end
          CARREGA: begin
            sombra[k] <= dado_rom;
            k         <= k + 2'd1;
            if (k == ULTIMO_K) begin
              estado <= PUBLICA;
            end
          end
          PUBLICA: begin
            janela        <= sombra_empacotada;
            quadro_pronto <= 1'b1;
            estado        <= ESPERA;
          end
          ESPERA: begin
            if (passo_terminal && habilita) begin
              posicao <= (posicao == ULTIMA_POSICAO) ? 5'd0 : posicao + 5'd1;
              k       <= '0;
              estado  <= CARREGA;
            end
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
